// File: rtl/ternary_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ternary_word_sequencer
// Description : Trit-serial sequencer that performs a WORD_TRITS-wide
//               balanced-ternary ADD / MUL / MIN / MAX by driving an external
//               single-trit ternary ALU one trit at a time. ADD uses two ALU
//               passes per trit (A+B, then +carry-in) and chains the carry.
//               Trit encoding: 00=Z, 01=P, 10=N, 11=invalid.
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous active-low reset
//               start      - operation request, sampled only in IDLE
//               op         - 00=add, 01=mul, 10=min, 11=max
//               a_word     - operand A, trit i at [2i+1:2i], trit 0 = LSB
//               b_word     - operand B, same layout
//               busy       - high while an operation is being sequenced
//               done       - one-cycle pulse, result valid
//               result     - assembled result word
//               carry_out  - final ADD carry trit (00 for other ops)
//               invalid    - an operand trit was 11 at accept
//               alu_a/alu_b/alu_op  - drives to the single-trit ALU
//               alu_out/alu_carry   - combinational ALU results
// Revision    : 1.0 - initial release
// ============================================================================
module ternary_word_sequencer #(
    parameter int WORD_TRITS = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [2*WORD_TRITS-1:0] a_word,
    input  logic [2*WORD_TRITS-1:0] b_word,
    output logic                    busy,
    output logic                    done,
    output logic [2*WORD_TRITS-1:0] result,
    output logic [1:0]              carry_out,
    output logic                    invalid,
    output logic [1:0]              alu_a,
    output logic [1:0]              alu_b,
    output logic [1:0]              alu_op,
    input  logic [1:0]              alu_out,
    input  logic [1:0]              alu_carry
);

    localparam int c_IW = (WORD_TRITS > 1) ? $clog2(WORD_TRITS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(WORD_TRITS - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADD1  = 3'd1;
    localparam logic [2:0] c_ADD2  = 3'd2;
    localparam logic [2:0] c_LOGIC = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_next;
    logic [WORD_TRITS-1:0][1:0]  r_a;
    logic [WORD_TRITS-1:0][1:0]  r_b;
    logic [WORD_TRITS-1:0][1:0]  r_result;
    logic [1:0]                  r_op;
    logic [c_IW-1:0]             r_idx;
    logic [1:0]                  r_cin;
    logic [1:0]                  r_s1;
    logic [1:0]                  r_c1;
    logic [1:0]                  r_carry_out;
    logic                        r_invalid;

    logic [2*WORD_TRITS-1:0]     w_a_clean;
    logic [2*WORD_TRITS-1:0]     w_b_clean;
    logic [WORD_TRITS-1:0]       w_a_bad;
    logic [WORD_TRITS-1:0]       w_b_bad;
    logic                        w_last;
    logic [1:0]                  w_cin_next;

    // Operand sanitising: any 11 trit is replaced by Z so the ALU never
    // sees the invalid code; the fact is remembered in invalid.
    for (genvar g = 0; g < WORD_TRITS; g++) begin : g_sanitise
        assign w_a_bad[g]           = &a_word[2*g +: 2];
        assign w_b_bad[g]           = &b_word[2*g +: 2];
        assign w_a_clean[2*g +: 2]  = w_a_bad[g] ? 2'b00 : a_word[2*g +: 2];
        assign w_b_clean[2*g +: 2]  = w_b_bad[g] ? 2'b00 : b_word[2*g +: 2];
    end

    function automatic logic signed [2:0] f_dec(input logic [1:0] t);
        case (t)
            2'b01:   f_dec = 3'sd1;
            2'b10:   f_dec = -3'sd1;
            default: f_dec = 3'sd0;
        endcase
    endfunction

    // The two partial carries of one trit never sum outside {-1,0,+1},
    // because |A[i]+B[i]+cin| <= 3.
    function automatic logic [1:0] f_carry_sum(input logic [1:0] x, input logic [1:0] y);
        logic signed [2:0] v_s;
        v_s = f_dec(x) + f_dec(y);
        case (v_s)
            3'sd1:   f_carry_sum = 2'b01;
            -3'sd1:  f_carry_sum = 2'b10;
            default: f_carry_sum = 2'b00;
        endcase
    endfunction

    assign w_last     = (r_idx == c_LAST);
    assign w_cin_next = f_carry_sum(r_c1, alu_carry);

    assign result     = r_result;
    assign carry_out  = r_carry_out;
    assign invalid    = r_invalid;

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_a        = 2'b00;
        alu_b        = 2'b00;
        alu_op       = 2'b00;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = (op == 2'b00) ? c_ADD1 : c_LOGIC;
                end
            end
            c_ADD1: begin
                busy         = 1'b1;
                alu_a        = r_a[r_idx];
                alu_b        = r_b[r_idx];
                w_state_next = c_ADD2;
            end
            c_ADD2: begin
                // Second pass folds the running carry into the partial sum.
                busy         = 1'b1;
                alu_a        = r_s1;
                alu_b        = r_cin;
                w_state_next = w_last ? c_DONE : c_ADD1;
            end
            c_LOGIC: begin
                busy         = 1'b1;
                alu_a        = r_a[r_idx];
                alu_b        = r_b[r_idx];
                alu_op       = r_op;
                w_state_next = w_last ? c_DONE : c_LOGIC;
            end
            c_DONE: begin
                done         = 1'b1;
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_op        <= 2'b00;
            r_idx       <= '0;
            r_cin       <= 2'b00;
            r_s1        <= 2'b00;
            r_c1        <= 2'b00;
            r_carry_out <= 2'b00;
            r_invalid   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a       <= w_a_clean;
                        r_b       <= w_b_clean;
                        r_op      <= op;
                        r_idx     <= '0;
                        r_cin     <= 2'b00;
                        r_invalid <= |{w_a_bad, w_b_bad};
                    end
                end
                c_ADD1: begin
                    r_s1 <= alu_out;
                    r_c1 <= alu_carry;
                end
                c_ADD2: begin
                    r_result[r_idx] <= alu_out;
                    r_cin           <= w_cin_next;
                    if (w_last) begin
                        r_carry_out <= w_cin_next;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_LOGIC: begin
                    r_result[r_idx] <= alu_out;
                    if (w_last) begin
                        r_carry_out <= 2'b00;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ternary_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ternary_word_sequencer
// Description : Directed self-checking bench for ternary_word_sequencer with
//               a behavioural single-trit ternary ALU attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ternary_word_sequencer;

    localparam int c_WT = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        op;
    logic [2*c_WT-1:0] a_word;
    logic [2*c_WT-1:0] b_word;
    logic              busy;
    logic              done;
    logic [2*c_WT-1:0] result;
    logic [1:0]        carry_out;
    logic              invalid;
    logic [1:0]        alu_a;
    logic [1:0]        alu_b;
    logic [1:0]        alu_op;
    logic [1:0]        alu_out;
    logic [1:0]        alu_carry;

    int n_assert = 0;
    int n_fail   = 0;
    int n_bad11  = 0;

    ternary_word_sequencer #(.WORD_TRITS(c_WT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a_word    (a_word),
        .b_word    (b_word),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .invalid   (invalid),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    always #5 clk = ~clk;

    // Behavioural single-trit ALU
    function automatic int f_dec(input logic [1:0] t);
        if (t == 2'b01) return 1;
        if (t == 2'b10) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] f_enc(input int v);
        if (v == 1)  return 2'b01;
        if (v == -1) return 2'b10;
        return 2'b00;
    endfunction

    int m_x, m_y, m_s;
    always_comb begin
        m_x       = f_dec(alu_a);
        m_y       = f_dec(alu_b);
        m_s       = 0;
        alu_out   = 2'b00;
        alu_carry = 2'b00;
        case (alu_op)
            2'b00: begin
                m_s = m_x + m_y;
                if (m_s > 1) begin
                    alu_out   = f_enc(m_s - 3);
                    alu_carry = 2'b01;
                end else if (m_s < -1) begin
                    alu_out   = f_enc(m_s + 3);
                    alu_carry = 2'b10;
                end else begin
                    alu_out   = f_enc(m_s);
                end
            end
            2'b01:   alu_out = f_enc(m_x * m_y);
            2'b10:   alu_out = f_enc((m_x < m_y) ? m_x : m_y);
            default: alu_out = f_enc((m_x > m_y) ? m_x : m_y);
        endcase
    end

    // Watch for the invalid code ever reaching the ALU
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (alu_a === 2'b11 || alu_b === 2'b11)) n_bad11++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [17:0] a, input logic [17:0] b);
        op     = o;
        a_word = a;
        b_word = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(inout int cyc);
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    int cyc;
    int dsum;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        a_word = '0;
        b_word = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    busy,      0);
        check("rst_done",    done,      0);
        check("rst_result",  result,    0);
        check("rst_carry",   carry_out, 0);
        check("rst_invalid", invalid,   0);
        check("rst_alu",     {alu_a, alu_b, alu_op}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: +1 + +1 = +2
        start_op(2'b00, 18'h00001, 18'h00001);
        cyc = 1;
        check("add1_busy",   busy,   1);
        check("add1_alu_op", alu_op, 2'b00);
        check("add1_alu_a",  alu_a,  2'b01);
        wait_done(cyc);
        check("add1_latency", cyc,       19);
        check("add1_result",  result,    18'h00006);
        check("add1_carry",   carry_out, 2'b00);
        check("add1_invalid", invalid,   0);
        check("add1_busy_done", busy,    0);
        @(posedge clk); #1;
        check("add1_done_pulse", done,   0);

        // 2: overflow wraps, carry out P
        start_op(2'b00, 18'h15555, 18'h00001);
        cyc = 1;
        wait_done(cyc);
        check("add2_latency", cyc,       19);
        check("add2_result",  result,    18'h2AAAA);
        check("add2_carry",   carry_out, 2'b01);
        @(posedge clk); #1;

        // 3: MUL (P,N,Z)*(N,N,P) trit-wise
        start_op(2'b01, 18'h00009, 18'h0001A);
        cyc = 1;
        check("mul_alu_op", alu_op, 2'b01);
        wait_done(cyc);
        check("mul_latency", cyc,       10);
        check("mul_result",  result,    18'h00006);
        check("mul_carry",   carry_out, 2'b00);
        @(posedge clk); #1;

        // 4: MIN then MAX
        start_op(2'b10, 18'h00009, 18'h0001A);
        cyc = 1;
        check("min_alu_op", alu_op, 2'b10);
        wait_done(cyc);
        check("min_latency", cyc,    10);
        check("min_result",  result, 18'h0000A);
        @(posedge clk); #1;
        start_op(2'b11, 18'h00009, 18'h0001A);
        cyc = 1;
        check("max_alu_op", alu_op, 2'b11);
        wait_done(cyc);
        check("max_result", result, 18'h00019);
        @(posedge clk); #1;

        // 5: invalid trit sanitised to Z
        start_op(2'b00, 18'h00003, 18'h00001);
        cyc = 1;
        check("inv_flag_busy", invalid, 1);
        wait_done(cyc);
        check("inv_result", result,    18'h00001);
        check("inv_carry",  carry_out, 2'b00);
        @(posedge clk); #1;
        check("inv_hold",   invalid,   1);
        check("inv_no_11",  n_bad11,   0);

        // 6a: start pulsed while busy is ignored; +4 + +1 = +5
        start_op(2'b00, 18'h00005, 18'h00001);
        cyc = 1;
        check("clr_invalid", invalid, 0);
        @(posedge clk); #1; cyc++;
        op     = 2'b01;
        a_word = 18'h2AAAA;
        b_word = 18'h15555;
        start  = 1'b1;
        @(posedge clk); #1; cyc++;
        start  = 1'b0;
        wait_done(cyc);
        check("ign_latency", cyc,    19);
        check("ign_result",  result, 18'h0001A);
        @(posedge clk); #1;
        check("ign_no_queue", busy,  0);

        // 6b: reset during ADD2 of trit 4
        start_op(2'b00, 18'h15555, 18'h00001);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_busy",    busy,  1);
        check("mid_add2_cin", alu_b, 2'b01);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy",   busy,   0);
        check("abort_done",   done,   0);
        check("abort_result", result, 0);
        check("abort_alu_a",  alu_a,  0);
        dsum = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dsum++;
        end
        check("abort_no_done", dsum, 0);

        // 6c: fresh operation after abort
        start_op(2'b11, 18'h00009, 18'h0001A);
        cyc = 1;
        wait_done(cyc);
        check("post_latency", cyc,    10);
        check("post_result",  result, 18'h00019);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
